// File: rtl/osc_pkg.sv
// osc_pkg: shared types for the oscilloscope capture datapath.
// Holds the capture FSM state encoding and the trigger mode encoding.
package osc_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PREFILL   = 3'd1;
  localparam logic [2:0] ST_WAIT_TRIG = 3'd2;
  localparam logic [2:0] ST_POST      = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  typedef enum logic [2:0] {
    CAP_IDLE      = ST_IDLE,
    CAP_PREFILL   = ST_PREFILL,
    CAP_WAIT_TRIG = ST_WAIT_TRIG,
    CAP_POST      = ST_POST,
    CAP_DONE      = ST_DONE
  } cap_state_e;

  typedef enum logic [1:0] {
    TRIG_RISE   = 2'b00,
    TRIG_FALL   = 2'b01,
    TRIG_EITHER = 2'b10,
    TRIG_IMM    = 2'b11
  } trig_mode_e;

endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port sample buffer, DEPTH words of W bits.
// One write port, one read port with a registered output that holds its
// value while re is low. Contents are not reset.
module capture_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 32
) (
  input  logic          clk_sys,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk_sys) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read port, output held when not reading
  always_ff @(posedge clk_sys) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mc_trigger_capture.sv
// mc_trigger_capture: multi-channel trigger-and-capture engine.
// Records NCH channels into a shared ring buffer with a pre-trigger depth,
// fires on a level crossing of the selected channel and streams the frame
// out oldest first over valid/ready.
// Optional feature macro AUTO_TRIG_EN: forces a trigger after AUTO_TIMEOUT
// sample strobes in WAIT_TRIG and flags it on auto_trig.
//
// state     | meaning
// IDLE      | waiting for arm
// PREFILL   | storing pre_len samples, triggers ignored
// WAIT_TRIG | storing samples and evaluating the trigger
// POST      | storing the rest of the frame after the trigger
// DONE      | streaming the frame out, oldest sample first
module mc_trigger_capture
  import osc_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int DW           = 8,
  parameter int DEPTH        = 1024,
  parameter int AW           = $clog2(DEPTH),
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [NCH*DW-1:0]        I_AD_Data,
  input  logic                     sample_en,
  input  logic                     arm,
  input  logic [$clog2(NCH)-1:0]   trig_ch,
  input  logic [DW-1:0]            trig_level,
  input  logic [1:0]               trig_mode,
  input  logic [AW-1:0]            pre_len,
  output logic                     busy,
  output logic                     trig_seen,
  output logic                     auto_trig,
  output logic [NCH*DW-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready
);

  cap_state_e              state;
  logic [$clog2(NCH)-1:0]  ch_q;
  logic [DW-1:0]           level_q;
  trig_mode_e              mode_q;
  logic [AW-1:0]           pre_q;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW-1:0]           cnt;
  logic [AW-1:0]           out_idx;
  logic [AW-1:0]           post_rem;
  logic [DW-1:0]           prev;
  logic [DW-1:0]           cur;
  logic                    prev_vld;
  logic                    rd_first;
  logic                    valid_q;
  logic                    seen_q;
  logic                    last;
  logic                    start;
  logic                    acc;
  logic                    rise;
  logic                    fall;
  logic                    hit;
  logic                    auto_fire;
  logic                    fire;
  logic                    rd_en;
  logic [NCH*DW-1:0]       rd_q;

  // arm restarts only from IDLE or DONE; in DONE it aborts the readout
  assign start    = arm && (state == CAP_IDLE || state == CAP_DONE);
  assign acc      = sample_en &&
                    (state == CAP_PREFILL || state == CAP_WAIT_TRIG || state == CAP_POST);
  assign cur      = I_AD_Data[int'(ch_q)*DW +: DW];
  assign rise     = prev_vld && (prev < level_q) && (cur >= level_q);
  assign fall     = prev_vld && (prev >= level_q) && (cur < level_q);
  assign post_rem = AW'(DEPTH - 1) - pre_q;
  assign last     = valid_q && (out_idx == AW'(DEPTH - 1));
  assign fire     = acc && (state == CAP_WAIT_TRIG) && (hit || auto_fire);
  assign rd_en    = (state == CAP_DONE) && (rd_first || (valid_q && out_ready && !last));

  assign busy      = (state == CAP_PREFILL) || (state == CAP_WAIT_TRIG) || (state == CAP_POST);
  assign trig_seen = seen_q;
  assign out_valid = valid_q;
  assign out_last  = last;
  assign out_data  = valid_q ? rd_q : '0;

  // trigger condition on the latched channel for the current sample
  always_comb begin
    hit = 1'b0;
    case (mode_q)
      TRIG_RISE:   hit = rise;
      TRIG_FALL:   hit = fall;
      TRIG_EITHER: hit = rise || fall;
      default:     hit = 1'b1;
    endcase
  end

`ifdef AUTO_TRIG_EN
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  logic          auto_q;

  assign auto_fire = acc && (state == CAP_WAIT_TRIG) && !hit && (to_cnt == TW'(1));
  assign auto_trig = auto_q;

  // timeout down-counter over WAIT_TRIG strobes, reloaded on every arm
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      to_cnt <= '0;
      auto_q <= 1'b0;
    end else if (start) begin
      to_cnt <= TW'(AUTO_TIMEOUT);
      auto_q <= 1'b0;
    end else begin
      if (acc && (state == CAP_WAIT_TRIG) && (to_cnt != '0)) to_cnt <= to_cnt - 1'b1;
      if (auto_fire) auto_q <= 1'b1;
    end
  end
`else
  logic unused_auto_timeout;

  assign auto_fire           = 1'b0;
  assign auto_trig           = 1'b0;
  assign unused_auto_timeout = ^AUTO_TIMEOUT;
`endif

  // capture FSM, pointers and readout handshake
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= CAP_IDLE;
      ch_q     <= '0;
      level_q  <= '0;
      mode_q   <= TRIG_RISE;
      pre_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      out_idx  <= '0;
      prev     <= '0;
      prev_vld <= 1'b0;
      rd_first <= 1'b0;
      valid_q  <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      if (acc) begin
        wr_ptr   <= wr_ptr + 1'b1;
        prev     <= cur;
        prev_vld <= 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;

      case (state)
        CAP_PREFILL: begin
          if (acc) begin
            if (cnt == AW'(1)) state <= CAP_WAIT_TRIG;
            else               cnt   <= cnt - 1'b1;
          end
        end
        CAP_WAIT_TRIG: begin
          if (fire) begin
            seen_q <= 1'b1;
            rd_ptr <= wr_ptr - pre_q;
            if (post_rem == '0) begin
              state    <= CAP_DONE;
              rd_first <= 1'b1;
              out_idx  <= '0;
            end else begin
              state <= CAP_POST;
              cnt   <= post_rem;
            end
          end
        end
        CAP_POST: begin
          if (acc) begin
            if (cnt == AW'(1)) begin
              state    <= CAP_DONE;
              rd_first <= 1'b1;
              out_idx  <= '0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        CAP_DONE: begin
          rd_first <= 1'b0;
          if (rd_en) valid_q <= 1'b1;
          if (valid_q && out_ready) begin
            if (last) begin
              valid_q <= 1'b0;
              state   <= CAP_IDLE;
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (start) begin
        ch_q     <= trig_ch;
        level_q  <= trig_level;
        mode_q   <= trig_mode_e'(trig_mode);
        pre_q    <= pre_len;
        cnt      <= pre_len;
        seen_q   <= 1'b0;
        prev_vld <= 1'b0;
        valid_q  <= 1'b0;
        rd_first <= 1'b0;
        out_idx  <= '0;
        state    <= (pre_len == '0) ? CAP_WAIT_TRIG : CAP_PREFILL;
      end
    end
  end

  capture_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (NCH*DW)
  ) u_ram (
    .clk_sys (Clk),
    .we      (acc),
    .waddr   (wr_ptr),
    .wdata   (I_AD_Data),
    .re      (rd_en),
    .raddr   (rd_ptr),
    .rdata   (rd_q)
  );

endmodule

// File: tb/tb_mc_trigger_capture.sv
// tb_mc_trigger_capture: table-driven bench with a readout scoreboard.
// Each vector describes a capture (config, per-channel ramps, hand-derived
// trigger sample index and value); the expected frame is queued when the
// capture is started and checked word by word as the DUT streams it.
module tb_mc_trigger_capture;

  localparam int NCH   = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic [NCH*DW-1:0] I_AD_Data = '0;
  logic              sample_en = 1'b0;
  logic              arm = 1'b0;
  logic              trig_ch = 1'b0;
  logic [DW-1:0]     trig_level = '0;
  logic [1:0]        trig_mode = 2'b00;
  logic [AW-1:0]     pre_len = '0;
  logic              busy;
  logic              trig_seen;
  logic              auto_trig;
  logic [NCH*DW-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready = 1'b1;

  mc_trigger_capture #(
    .NCH(NCH), .DW(DW), .DEPTH(DEPTH), .AW(AW), .AUTO_TIMEOUT(8)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .I_AD_Data(I_AD_Data), .sample_en(sample_en),
    .arm(arm), .trig_ch(trig_ch), .trig_level(trig_level), .trig_mode(trig_mode),
    .pre_len(pre_len), .busy(busy), .trig_seen(trig_seen), .auto_trig(auto_trig),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int mode; int ch; int level; int pre;
    int s0; int d0; int s1; int d1;
    int toggle; int exp_k; int exp_ch; int exp_val; int exp_auto;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          rdy_mode = 0;
  logic [15:0] got[DEPTH];
  int          got_n = 0;
  int          cyc = 0;
  int          t_first = 0;
  int          t_last = 0;

  function automatic logic [15:0] sample_word(input vec_t v, input int k);
    logic [7:0] a;
    logic [7:0] b;
    a = 8'(v.s0 + k * v.d0);
    b = 8'(v.s1 + k * v.d1);
    return {b, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] g, input logic [31:0] w);
    total++;
    if (g !== w) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, g, w);
    end
  endtask

  // out_ready pattern: always high, or toggling every cycle
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (rdy_mode != 0) out_ready = ~out_ready;
      else               out_ready = 1'b1;
    end
  end

  // readout monitor: scoreboard pops and stall-hold checks
  initial begin
    exp_t        e;
    logic        stall_prev;
    logic [15:0] stall_data;
    logic        stall_last;
    stall_prev = 1'b0;
    stall_data = '0;
    stall_last = 1'b0;
    forever begin
      @(negedge Clk);
      cyc++;
      if (!Reset_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && out_valid) begin
          total++;
          if (out_data !== stall_data || out_last !== stall_last) begin
            bad++;
            $display("FAIL stall_hold data=%h last=%b want data=%h last=%b",
                     out_data, out_last, stall_data, stall_last);
          end
        end
        if (out_valid && out_ready) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_word data=%h want no transfer", out_data);
          end else begin
            e = sb.pop_front();
            if (out_data !== e.data || out_last !== e.last) begin
              bad++;
              $display("FAIL word%0d data=%h last=%b want data=%h last=%b",
                       got_n, out_data, out_last, e.data, e.last);
            end
            if (got_n < DEPTH) got[got_n] = out_data;
            if (got_n == 0) t_first = cyc;
            t_last = cyc;
            got_n++;
          end
        end
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        stall_last = out_last;
      end
    end
  end

  task automatic drive_sample(input logic [15:0] w);
    @(posedge Clk);
    #1;
    sample_en = 1'b1;
    I_AD_Data = w;
    @(posedge Clk);
    #1;
    sample_en = 1'b0;
    I_AD_Data = ~w;
    repeat (2) @(posedge Clk);
  endtask

  // arm pulse, then scramble the config inputs so only latched values matter
  task automatic do_arm(input vec_t v);
    @(posedge Clk);
    #1;
    arm        = 1'b1;
    trig_ch    = v.ch[0];
    trig_level = 8'(v.level);
    trig_mode  = 2'(v.mode);
    pre_len    = 4'(v.pre);
    @(posedge Clk);
    #1;
    arm        = 1'b0;
    trig_ch    = ~trig_ch;
    trig_level = 8'(v.level + 77);
    trig_mode  = 2'b11;
    pre_len    = 4'(v.pre + 5);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    exp_t e;
    int   n;
    int   w;
    n = v.exp_k + DEPTH - v.pre;
    got_n = 0;
    rdy_mode = v.toggle;
    for (int j = 0; j < DEPTH; j++) begin
      e.data = sample_word(v, v.exp_k - v.pre + j);
      e.last = (j == DEPTH - 1);
      sb.push_back(e);
    end
    do_arm(v);
    @(negedge Clk);
    chk({name, "_busy_armed"}, 32'(busy), 1);
    chk({name, "_seen_cleared"}, 32'(trig_seen), 0);
    for (int k = 0; k < n + 2; k++) drive_sample(sample_word(v, k));
    w = 0;
    while ((sb.size() != 0 || out_valid) && w < 400) begin
      @(negedge Clk);
      w++;
    end
    total++;
    if (w >= 400) begin
      bad++;
      $display("FAIL %s_timeout pending=%0d want 0", name, sb.size());
      sb.delete();
    end
    chk({name, "_trig_seen"}, 32'(trig_seen), 1);
    chk({name, "_auto_trig"}, 32'(auto_trig), 32'(v.exp_auto));
    chk({name, "_busy_end"}, 32'(busy), 0);
    chk({name, "_words"}, 32'(got_n), DEPTH);
    if (got_n > v.pre)
      chk({name, "_trig_word"}, 32'(got[v.pre][v.exp_ch*8 +: 8]), 32'(v.exp_val));
    if (v.toggle == 0 && got_n == DEPTH)
      chk({name, "_no_bubble"}, 32'(t_last - t_first), DEPTH - 1);
    rdy_mode = 0;
  endtask

  vec_t vecs[6];
  vec_t v_after;
  vec_t v_auto;

  initial begin
    //          mode ch lvl pre  s0  d0  s1   d1 tog k  ech val auto
    vecs[0] = '{0,   0, 100, 4,   0, 10,   5,   1, 0, 10, 0, 100, 0};
    vecs[1] = '{1,   1, 100, 2,   7,  3, 200, -25, 0,  5, 1,  75, 0};
    vecs[2] = '{3,   0,   0, 0,  33,  1,   9,   2, 0,  0, 0,  33, 0};
    vecs[3] = '{2,   0, 100, 8,   0, 10,   0,   5, 1, 10, 0, 100, 0};
    vecs[4] = '{0,   0, 100, 15,  0,  5,   3,   7, 0, 20, 0, 100, 0};
    vecs[5] = '{0,   0,  50, 0, 200, 20,   1,   1, 0,  6, 0,  64, 0};
    v_after = '{0,   0,  50, 4,   0, 10,  90,   3, 0,  5, 0,  50, 0};
    v_auto  = '{0,   0, 100, 2,  30,  0,   0,   1, 0,  9, 1,   9, 1};

    repeat (3) @(negedge Clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_trig_seen", 32'(trig_seen), 0);
    chk("rst_auto_trig", 32'(auto_trig), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_data", 32'(out_data), 0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // reset mid-POST, with an ignored arm while busy
    do_arm(vecs[0]);
    for (int k = 0; k < 13; k++) drive_sample(sample_word(vecs[0], k));
    do_arm(vecs[2]);
    drive_sample(sample_word(vecs[0], 13));
    @(negedge Clk);
    chk("post_busy", 32'(busy), 1);
    chk("post_seen_kept", 32'(trig_seen), 1);
    @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    @(negedge Clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_seen", 32'(trig_seen), 0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    run_vec("after_rst", v_after);

`ifdef AUTO_TRIG_EN
    run_vec("auto", v_auto);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_trigger_capture.md
# mc_trigger_capture

Parametrised multi-channel trigger-and-capture engine for the oscilloscope datapath. It sits between the ADC input registers and the UART frame packer. It records NCH channels into a shared ring buffer with a programmable pre-trigger depth and fires on a selectable channel's level crossing. It then streams the captured frame out, oldest sample first, over a valid/ready handshake.

## Interface
- NCH, 4: number of ADC channels.
- DW, 8: sample width per channel.
- DEPTH, 1024: samples per channel per capture; power of two.
- AW, $clog2(DEPTH): buffer address width (derived).
- AUTO_TIMEOUT, 65535: sample strobes before auto-trigger (AUTO_TRIG_EN only).
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- I_AD_Data  in  NCH*DW  packed samples; channel k is at [k*DW +: DW].
- sample_en  in  1  one-cycle strobe; I_AD_Data valid this cycle.
- arm  in  1  pulse; starts a capture.
- trig_ch  in  $clog2(NCH)  trigger source channel.
- trig_level  in  DW  unsigned trigger level.
- trig_mode  in  2  00 rising, 01 falling, 10 either, 11 immediate.
- pre_len  in  AW  samples kept before the trigger.
- busy  out  1  high in PREFILL/WAIT_TRIG/POST.
- trig_seen  out  1  set on trigger; cleared on arm.
- auto_trig  out  1  trigger was forced by timeout.
- out_data  out  NCH*DW  readout word.
- out_valid  out  1  readout word valid.
- out_last  out  1  final word of the frame.
- out_ready  in  1  consumer accepts out_data.

## Operation
- trig_ch, trig_level, trig_mode and pre_len are latched on arm. Later changes have no effect until the next arm.
- Every accepted sample writes the ring buffer at wr_ptr; wr_ptr increments modulo DEPTH.
- States:
  - IDLE: waits for arm.
  - PREFILL: accepts pre_len samples; triggers are ignored. Skipped when pre_len=0.
  - WAIT_TRIG: writes continuously and evaluates the trigger.
  - POST: captures until DEPTH-pre_len samples, trigger sample included, are stored after the trigger.
  - DONE: streams the frame, then returns to IDLE.
- Trigger evaluation uses prev and cur, unsigned, on the latched channel:
  - rising: prev<level && cur>=level.
  - falling: prev>=level && cur<level.
  - either: rising or falling.
  - immediate: the first sample in WAIT_TRIG.
  - prev is invalid for the first sample after arm, so that sample cannot fire an edge trigger.
- Trigger address trig_addr = the write address of the triggering sample.
- Readout start = (trig_addr - pre_len) mod DEPTH. The frame is DEPTH words, and the trigger sample is word index pre_len.
- arm in DONE aborts readout: out_valid drops next cycle and a new capture starts. arm in busy states is ignored.
- sample_en is ignored in IDLE and DONE.

## Timing
- Reset values: all outputs 0, state IDLE, pointers 0.
- A sample is written the cycle after sample_en. Trigger fires combinationally on cur and registers into the state change on the next edge.
- Buffer read latency is 1 cycle. out_valid rises within 2 cycles of entering DONE.
- Handshake:
  - A word transfers on out_valid && out_ready.
  - out_data and out_last hold stable while out_valid && !out_ready.
  - No bubbles under continuous out_ready after the first word.
- out_last is asserted with word DEPTH-1. out_valid deasserts the cycle after that transfer, and state returns to IDLE.
- busy falls on the cycle DONE is entered.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Buffer contents are undefined.

## Configuration
- AUTO_TRIG_EN defined:
  - A counter of sample strobes runs in WAIT_TRIG.
  - When the count reaches AUTO_TIMEOUT, that sample triggers and auto_trig is set.
  - auto_trig is cleared on arm.
- AUTO_TRIG_EN undefined:
  - No counter is built, auto_trig is tied 0, and AUTO_TIMEOUT is unused.
  - WAIT_TRIG waits indefinitely.

## Structure
- Shared package osc_pkg holds the trig_mode_e enum (TRIG_RISE, TRIG_FALL, TRIG_EITHER, TRIG_IMM) and the cap_state_e enum.
- Sub-module capture_ram: simple dual-port memory, DEPTH x NCH*DW, one write port, registered read port.

## Test plan
All scenarios use NCH=2, DW=8, DEPTH=16.
1. Rising trigger: level 100, pre_len 4, ch0 ramps 0,10,20… every 4th cycle -> 16 words; word4 ch0=100, word3 ch0=90, out_last on word 15.
2. Falling trigger on ch1: ch1 ramps down from 200 in steps of 25, level 100 -> trigger sample ch1=100 (at level, but cur>=level, so it does not fire); first firing sample 75 appears at word pre_len.
3. pre_len=0, immediate mode -> PREFILL skipped; word0 = first sample after arm, trig_seen=1.
4. out_ready toggled 1010…: all 16 words delivered in order, none duplicated, out_data stable while stalled.
5. Reset_n pulled low mid-POST -> next cycle busy=0, out_valid=0; a new arm with level 50 then completes a normal frame.
6. AUTO_TRIG_EN with AUTO_TIMEOUT=8 and constant input 30, level 100 -> trigger on the 8th WAIT_TRIG sample, auto_trig=1, frame delivered.
